// File: rtl/atm_account_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | atm_account_responder                                                      |
// | Bank-side account table serving VERIFY/BALANCE/WITHDRAW/DEPOSIT requests.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module atm_account_responder #(
  parameter int          NUM_ACCTS    = 4,
  parameter int          ACCT_W       = 2,
  parameter logic [15:0] INIT_BALANCE = 16'd1000,
  parameter logic [15:0] PIN_BASE     = 16'd1234,
  parameter int          MAX_TRIES    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ACCT_W-1:0] req_acct,
  input  logic [15:0]       req_pin,
  input  logic [15:0]       req_amount,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [2:0]        resp_status,
  output logic [15:0]       resp_balance
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam logic [FAIL_W-1:0] c_max_fail = FAIL_W'(MAX_TRIES);

  localparam logic [1:0] c_op_withdraw = 2'b10;
  localparam logic [1:0] c_op_deposit  = 2'b11;

  localparam logic [2:0] c_st_ok       = 3'd0;
  localparam logic [2:0] c_st_bad_pin  = 3'd1;
  localparam logic [2:0] c_st_locked   = 3'd2;
  localparam logic [2:0] c_st_insuff   = 3'd3;
  localparam logic [2:0] c_st_overflow = 3'd4;
  localparam logic [2:0] c_st_bad_acct = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ACCT_W-1:0]   acct_q, acct_d;
  logic [15:0]         pin_q, pin_d;
  logic [15:0]         amount_q, amount_d;
  logic [15:0]         bal_q  [NUM_ACCTS];
  logic [15:0]         bal_d  [NUM_ACCTS];
  logic [FAIL_W-1:0]   fail_q [NUM_ACCTS];
  logic [FAIL_W-1:0]   fail_d [NUM_ACCTS];
  logic [2:0]          resp_status_q, resp_status_d;
  logic [15:0]         resp_balance_q, resp_balance_d;

  logic                acct_hit;
  logic [15:0]         cur_bal;
  logic [15:0]         cur_pin;
  logic [FAIL_W-1:0]   cur_fail;
  logic [15:0]         new_bal;
  logic [FAIL_W-1:0]   new_fail;
  logic [16:0]         dep_sum;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    acct_d         = acct_q;
    pin_d          = pin_q;
    amount_d       = amount_q;
    bal_d          = bal_q;
    fail_d         = fail_q;
    resp_status_d  = resp_status_q;
    resp_balance_d = resp_balance_q;
    acct_hit       = 1'b0;
    cur_bal        = '0;
    cur_pin        = '0;
    cur_fail       = '0;

    // PINs are fixed after reset, so they are derived from the account id
    for (int i = 0; i < NUM_ACCTS; i++) begin
      if (acct_q == ACCT_W'(i)) begin
        acct_hit = 1'b1;
        cur_bal  = bal_q[i];
        cur_fail = fail_q[i];
        cur_pin  = PIN_BASE + 16'(i);
      end
    end

    dep_sum  = {1'b0, cur_bal} + {1'b0, amount_q};
    new_bal  = cur_bal;
    new_fail = cur_fail;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          acct_d   = req_acct;
          pin_d    = req_pin;
          amount_d = req_amount;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        resp_balance_d = '0;
        if (!acct_hit) begin
          resp_status_d = c_st_bad_acct;
        end else if (cur_fail == c_max_fail) begin
          resp_status_d = c_st_locked;
        end else if (pin_q != cur_pin) begin
          resp_status_d = c_st_bad_pin;
          new_fail      = cur_fail + 1'b1;
        end else begin
          new_fail      = '0;
          resp_status_d = c_st_ok;
          if (op_q == c_op_withdraw) begin
            if (amount_q > cur_bal) resp_status_d = c_st_insuff;
            else                    new_bal = cur_bal - amount_q;
          end else if (op_q == c_op_deposit) begin
            if (dep_sum[16]) resp_status_d = c_st_overflow;
            else             new_bal = dep_sum[15:0];
          end
          resp_balance_d = new_bal;
        end
        for (int i = 0; i < NUM_ACCTS; i++) begin
          if (acct_q == ACCT_W'(i)) begin
            bal_d[i]  = new_bal;
            fail_d[i] = new_fail;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      op_q           <= '0;
      acct_q         <= '0;
      pin_q          <= '0;
      amount_q       <= '0;
      resp_status_q  <= '0;
      resp_balance_q <= '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_q[i]  <= INIT_BALANCE;
        fail_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      acct_q         <= acct_d;
      pin_q          <= pin_d;
      amount_q       <= amount_d;
      resp_status_q  <= resp_status_d;
      resp_balance_q <= resp_balance_d;
      bal_q          <= bal_d;
      fail_q         <= fail_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_status  = resp_status_q;
  assign resp_balance = resp_balance_q;

endmodule
`default_nettype wire

// File: tb/tb_atm_account_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_atm_account_responder                                                   |
// | Directed self-checking bench; a second 3-account instance covers BAD_ACCT. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_atm_account_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [1:0]  req_acct;
  logic [15:0] req_pin;
  logic [15:0] req_amount;
  logic        resp_ready;

  logic        req_ready,  req_ready2;
  logic        resp_valid, resp_valid2;
  logic [2:0]  resp_status, resp_status2;
  logic [15:0] resp_balance, resp_balance2;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  last_st, last_st2;
  logic [15:0] last_bal, last_bal2;

  always #5 clk = ~clk;

  atm_account_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_acct(req_acct), .req_pin(req_pin), .req_amount(req_amount),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_status(resp_status), .resp_balance(resp_balance)
  );

  atm_account_responder #(.NUM_ACCTS(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready2), .req_op(req_op),
    .req_acct(req_acct), .req_pin(req_pin), .req_amount(req_amount),
    .resp_valid(resp_valid2), .resp_ready(resp_ready),
    .resp_status(resp_status2), .resp_balance(resp_balance2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accept a request and wait (bounded) for the response to appear
  task automatic start_req(input logic [1:0] op, input logic [1:0] acct,
                           input logic [15:0] pin, input logic [15:0] amt);
    int n;
    req_op     = op;
    req_acct   = acct;
    req_pin    = pin;
    req_amount = amt;
    req_valid  = 1'b1;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_op     = ~op;
    req_pin    = ~pin;
    req_amount = 16'hFFFF;
    n = 0;
    while (!resp_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("resp_latency", n, 32'd1);
    last_st   = resp_status;
    last_bal  = resp_balance;
    last_st2  = resp_status2;
    last_bal2 = resp_balance2;
  endtask

  task automatic finish_req;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic exp_txn(input string tag, input logic [1:0] op, input logic [1:0] acct,
                         input logic [15:0] pin, input logic [15:0] amt,
                         input logic [2:0] exp_st, input logic [15:0] exp_bal);
    start_req(op, acct, pin, amt);
    finish_req();
    check({tag, "_status"}, {29'd0, last_st}, {29'd0, exp_st});
    check({tag, "_balance"}, {16'd0, last_bal}, {16'd0, exp_bal});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_acct = '0;
    req_pin = '0; req_amount = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_status", {29'd0, resp_status}, 32'd0);
    check("rst_resp_balance", {16'd0, resp_balance}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);

    exp_txn("verify0", 2'b00, 2'd0, 16'd1234, 16'd0, 3'd0, 16'd1000);

    exp_txn("wd300", 2'b10, 2'd1, 16'd1235, 16'd300, 3'd0, 16'd700);
    exp_txn("wd701", 2'b10, 2'd1, 16'd1235, 16'd701, 3'd3, 16'd700);
    exp_txn("wd700", 2'b10, 2'd1, 16'd1235, 16'd700, 3'd0, 16'd0);
    exp_txn("wd0",   2'b10, 2'd1, 16'd1235, 16'd0,   3'd0, 16'd0);

    exp_txn("dep64535", 2'b11, 2'd2, 16'd1236, 16'd64535, 3'd0, 16'd65535);
    exp_txn("dep1_ovf", 2'b11, 2'd2, 16'd1236, 16'd1,     3'd4, 16'd65535);

    for (int i = 0; i < 3; i++)
      exp_txn("badpin3", 2'b01, 2'd3, 16'd0, 16'd0, 3'd1, 16'd0);
    exp_txn("locked3", 2'b01, 2'd3, 16'd1237, 16'd0, 3'd2, 16'd0);
    exp_txn("acct0_ok", 2'b01, 2'd0, 16'd1234, 16'd0, 3'd0, 16'd1000);

    // Two bad then good, twice: only works if the good PIN clears the count
    for (int r = 0; r < 2; r++) begin
      exp_txn("clr_bad_a", 2'b00, 2'd0, 16'd9, 16'd0, 3'd1, 16'd0);
      exp_txn("clr_bad_b", 2'b00, 2'd0, 16'd9, 16'd0, 3'd1, 16'd0);
      exp_txn("clr_good",  2'b00, 2'd0, 16'd1234, 16'd0, 3'd0, 16'd1000);
    end

    // Reset with req_valid high in the same cycle: nothing accepted
    reset = 1'b1; req_valid = 1'b1; req_op = 2'b00; req_acct = 2'd0; req_pin = 16'd1234;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    check("rst_wins_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check("rst_wins_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_wins_ready2", {31'd0, req_ready}, 32'd1);

    exp_txn("reinit_acct1", 2'b01, 2'd1, 16'd1235, 16'd0, 3'd0, 16'd1000);
    exp_txn("reinit_acct2", 2'b01, 2'd2, 16'd1236, 16'd0, 3'd0, 16'd1000);

    // Account 3 is out of range only for the 3-account instance
    exp_txn("unlock3_dep", 2'b11, 2'd3, 16'd1237, 16'd500, 3'd0, 16'd1500);
    check("badacct_status", {29'd0, last_st2}, 32'd5);
    check("badacct_balance", {16'd0, last_bal2}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      start_req(2'b01, 2'(i), 16'd1234 + 16'(i), 16'd0);
      finish_req();
      check("badacct_other_status", {29'd0, last_st2}, 32'd0);
      check("badacct_other_balance", {16'd0, last_bal2}, 32'd1000);
    end

    // Response held under back-pressure, then reset drops it and the update
    start_req(2'b10, 2'd0, 16'd1234, 16'd100);
    check("hold_status0", {29'd0, last_st}, 32'd0);
    check("hold_balance0", {16'd0, last_bal}, 32'd900);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_status", {29'd0, resp_status}, 32'd0);
      check("hold_balance", {16'd0, resp_balance}, 32'd900);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    exp_txn("midrst_bal", 2'b01, 2'd0, 16'd1234, 16'd0, 3'd0, 16'd1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
